// File: rtl/prio_scan_enc.sv
// ============================================================================
// Module   : prio_scan_enc
// Purpose  : Sequential priority scanner; emits one set-bit index per accepted
//            handshake. Define PRIO_SCAN_MSB_FIRST_EN for highest-first order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_scan_enc #(
    parameter int WIDTH = 16,
    parameter int IDXW  = $clog2(WIDTH),
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] req,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic [CNTW-1:0]  count
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             out_valid_q, out_valid_d;
    logic [IDXW-1:0]  out_idx_q, out_idx_d;
    logic             out_last_q, out_last_d;
    logic             done_q, done_d;
    logic [CNTW-1:0]  count_q, count_d;

    logic [WIDTH-1:0] w_mask_clr;
    logic [IDXW-1:0]  w_req_idx;
    logic [IDXW-1:0]  w_clr_idx;

    // Index of the bit that is scanned next in the compile-time order.
    function automatic logic [IDXW-1:0] pick_idx(input logic [WIDTH-1:0] m);
        logic [IDXW-1:0] idx;
        idx = '0;
`ifdef PRIO_SCAN_MSB_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (m[i]) idx = IDXW'(i);
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (m[i]) idx = IDXW'(i);
        end
`endif
        return idx;
    endfunction

    function automatic logic single_bit(input logic [WIDTH-1:0] m);
        return (m != '0) && ((m & (m - WIDTH'(1))) == '0);
    endfunction

    assign w_mask_clr = mask_q & ~(WIDTH'(1) << out_idx_q);
    assign w_req_idx  = pick_idx(req);
    assign w_clr_idx  = pick_idx(w_mask_clr);

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        count_d     = count_q;

        case (state_q)
            ST_IDLE: begin
                // abort outranks load while idle
                if (load && !abort) begin
                    count_d = '0;
                    if (req != '0) begin
                        state_d     = ST_SCAN;
                        mask_d      = req;
                        out_valid_d = 1'b1;
                        out_idx_d   = w_req_idx;
                        out_last_d  = single_bit(req);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    mask_d      = '0;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else if (out_valid_q && out_ready) begin
                    count_d = count_q + CNTW'(1);
                    mask_d  = w_mask_clr;
                    if (w_mask_clr != '0) begin
                        out_idx_d  = w_clr_idx;
                        out_last_d = single_bit(w_mask_clr);
                    end else begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                mask_d      = '0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            count_q     <= count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q == ST_SCAN);
    assign done      = done_q;
    assign count     = count_q;

endmodule

`default_nettype wire

// File: doc/prio_scan_enc.md
Name: prio_scan_enc

Overview:
- Sequential, parametrised successor to the combinational 16-bit priority encoder.
- Latches a WIDTH-bit request mask and emits the index of every set bit, one per accepted handshake, lowest index first.
- Clears each bit as it is consumed and pulses done when the mask is exhausted.
- Feeds SPU multi-register operations (register-list push/pop) and interrupt servicing, where each set bit needs its own cycle.

Parameters:
- WIDTH, 16, request vector width; legal range 2..64.
- IDXW, $clog2(WIDTH), width of the emitted index.
- CNTW, $clog2(WIDTH+1), width of the count of indices emitted.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- load  in  1  capture req and start a scan; honoured only in IDLE.
- req  in  WIDTH  request mask sampled when a load is honoured.
- abort  in  1  discard the remaining mask and return to IDLE.
- out_ready  in  1  consumer accepts out_idx this cycle.
- out_valid  out  1  out_idx holds a pending set-bit index.
- out_idx  out  IDXW  index of the current highest-priority remaining bit.
- out_last  out  1  the current index is the final set bit of the mask.
- busy  out  1  high in SCAN.
- done  out  1  one-cycle pulse when a scan completes normally.
- count  out  CNTW  indices accepted in the current or most recent scan.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; mask=0; out_valid=0; out_idx=0; out_last=0; busy=0; done=0; count=0. rst_n dominates load and abort.
- All outputs are registered. No combinational path from any input to any output.
- IDLE, load=1, req!=0:
  - Next cycle: state=SCAN, mask=req, count=0.
  - out_valid=1, out_idx=lowest set bit of req.
  - out_last=1 if popcount(req)==1.
  - First index is valid one cycle after load.
- IDLE, load=1, req==0:
  - Stay IDLE; count=0; done pulses the next cycle; out_valid stays 0.
- SCAN, out_valid=1 and out_ready=1 (accept):
  - Clear bit out_idx in mask; count=count+1.
  - If bits remain: next cycle out_idx=next lowest remaining bit, out_valid stays 1, out_last recomputed. One index per cycle while out_ready is held high.
  - If mask becomes 0: next cycle state=IDLE, out_valid=0, out_last=0, busy=0, done=1 for exactly one cycle.
- SCAN, out_ready=0: out_idx, out_last and mask hold stable. out_valid must not drop without an accept.
- load while in SCAN: ignored; mask is not modified.
- abort=1 in SCAN:
  - Next cycle: IDLE, mask=0, out_valid=0, out_last=0, busy=0, done stays 0.
  - count holds the number of indices accepted before the abort.
  - A handshake in the same cycle as abort is not counted.
- abort in IDLE: no effect, and it takes priority over a simultaneous load.
- Back-to-back scans: load may be asserted in the cycle done is high (state is IDLE). It is honoured normally, with no idle gap required.
- count saturates naturally at WIDTH; it cannot exceed popcount(req).
- out_idx when out_valid=0: holds its last value. The bench must not check it.

Optional Feature:
- Macro: PRIO_SCAN_MSB_FIRST_EN.
- Defined: a load/mode input is not added. The scan order is compile-time highest index first; out_idx is the highest remaining set bit and out_last semantics are unchanged.
- Undefined (default): lowest index first, as specified above.
- All other timing is identical in both builds.

Test Plan:
- Reset, then load=1 with req=16'h8421 and out_ready=1 held:
  - out_idx = 0, 5, 10, 15 on four consecutive cycles.
  - out_last=1 only with 15.
  - done pulses the following cycle; count=4.
- Load req=16'h0000:
  - No out_valid.
  - done pulses one cycle after load; count=0; busy stays 0.
- Load req=16'h00F0, out_ready toggled 1,0,0,1,1,1:
  - out_idx holds 4 then 5 through stalls; sequence 4,5,6,7 completes.
  - count=4.
- Load req=16'hFFFF, abort asserted after 3 accepts:
  - Next cycle out_valid=0, busy=0, no done pulse, count=3.
  - A subsequent load of 16'h0002 yields out_idx=1, out_last=1.
- Load asserted again while busy with a different req:
  - Ignored; the original sequence is unchanged.
  - Load in the done cycle starts the next scan with no gap.
- Build with PRIO_SCAN_MSB_FIRST_EN and req=16'h8421: out_idx = 15, 10, 5, 0, with out_last=1 on 0.
